// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - multi-port req/gnt/rvalid arbiter sharing one single-ported SRAM
// Grants one master per cycle, issues the SRAM access combinationally, responds one cycle later.
module core_mem_arbiter #(
    parameter int                    NUM_PORTS  = 2,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter int                    MEM_WORDS  = 4096,
    parameter int                    ARB_MODE   = 0,
    localparam int                   BE_WIDTH   = DATA_WIDTH / 8,
    localparam int                   MEM_AW     = $clog2(MEM_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    output logic [NUM_PORTS-1:0]             err_o,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]    be_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             mem_en_o,
    output logic                             mem_we_o,
    output logic [BE_WIDTH-1:0]              mem_be_o,
    output logic [MEM_AW-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

    localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BYTE_SH = $clog2(BE_WIDTH);
    localparam logic [ADDR_WIDTH:0] WIN_BYTES =
        (ADDR_WIDTH+1)'(MEM_WORDS) * (ADDR_WIDTH+1)'(BE_WIDTH);

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_resp_valid;
    logic [PTR_W-1:0]      r_resp_port;
    logic                  r_resp_err;
    logic                  r_resp_rd;

    logic                  w_found;
    logic                  w_any;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_cand;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_in_win;
    logic                  w_we;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Search from the round-robin pointer (or from port 0 in fixed mode), wrapping modulo NUM_PORTS.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            if (ARB_MODE == 1) begin
                w_cand = PTR_W'(off);
            end else begin
                w_cand = PTR_W'((int'(r_ptr) + off) % NUM_PORTS);
            end
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // Grants are suppressed combinationally while reset is held low.
    assign w_any = w_found & rst;

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt_o[i] = w_any && (w_idx == PTR_W'(i));
        end
    end

    assign w_addr   = addr_i[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_we     = we_i[w_idx];
    assign w_be     = be_i[w_idx*BE_WIDTH +: BE_WIDTH];
    assign w_wdata  = wdata_i[w_idx*DATA_WIDTH +: DATA_WIDTH];

    // Offset is only meaningful when addr >= MEM_BASE; the extra bit keeps the upper compare overflow-free.
    assign w_offset = w_addr - MEM_BASE;
    assign w_in_win = (w_addr >= MEM_BASE) && ({1'b0, w_offset} < WIN_BYTES);

    assign mem_en_o    = w_any & w_in_win;
    assign mem_we_o    = mem_en_o & w_we;
    assign mem_be_o    = mem_en_o ? w_be : '0;
    assign mem_addr_o  = mem_en_o ? w_offset[BYTE_SH +: MEM_AW] : '0;
    assign mem_wdata_o = mem_en_o ? w_wdata : '0;

    assign w_ptr_nxt = (w_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_port  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rd    <= 1'b0;
        end else begin
            r_resp_valid <= w_any;
            r_resp_port  <= w_idx;
            r_resp_err   <= w_any & ~w_in_win;
            r_resp_rd    <= w_any & w_in_win & ~w_we;
            if (w_any) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rvalid_o[i] = r_resp_valid && (r_resp_port == PTR_W'(i));
            err_o[i]    = r_resp_valid && (r_resp_port == PTR_W'(i)) && r_resp_err;
        end
    end

    // Writes and error responses return zero data.
    assign rdata_o = r_resp_rd ? mem_rdata_i : '0;

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Parametrised multi-port memory arbiter for the processor block. It lets NUM_PORTS Ibex-style req/gnt/rvalid masters (instruction fetch, data port, later a DMA or debug master) share one single-ported synchronous SRAM. It arbitrates one request per cycle, decodes the address window, returns a read/write response exactly one cycle after grant, and flags out-of-window accesses with an error response instead of touching memory.

## Interface
Parameters:
- NUM_PORTS, 2: number of master ports (1..8).
- DATA_WIDTH, 32: data width; must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- ADDR_WIDTH, 32: master byte-address width.
- MEM_BASE, 32'h0000_0000: byte base address of the SRAM window; must be word-aligned.
- MEM_WORDS, 4096: SRAM depth in words (power of two). MEM_AW = $clog2(MEM_WORDS).
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, where port 0 is highest.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- gnt_o  out  NUM_PORTS  per-port grant; combinational, one-hot or zero.
- rvalid_o  out  NUM_PORTS  per-port response valid; one-hot or zero.
- err_o  out  NUM_PORTS  per-port response error; asserted only with the matching rvalid_o.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  NUM_PORTS*BE_WIDTH  per-port byte enables.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port byte address.
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- rdata_o  out  DATA_WIDTH  shared read data; qualified by rvalid_o.
- mem_en_o  out  1  SRAM access enable.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  BE_WIDTH  SRAM byte enables.
- mem_addr_o  out  MEM_AW  SRAM word address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data; valid one cycle after mem_en_o.

## Operation
- **Arbitration**
  - Each cycle, the winner is chosen from the ports with req_i asserted. gnt_o is set for the winner only.
  - No grant is issued while rst is low.
  - Round-robin: a pointer resets to 0. The search runs from the pointer upward and wraps modulo NUM_PORTS. After a grant to port k, the pointer becomes (k+1) mod NUM_PORTS. The pointer does not move in cycles with no grant.
  - Fixed priority: the lowest-index requesting port wins.
- **Decode**
  - A request is in window when MEM_BASE <= addr < MEM_BASE + MEM_WORDS*BE_WIDTH, using unsigned, full ADDR_WIDTH compare without overflow.
  - mem_addr_o = (addr - MEM_BASE) >> $clog2(BE_WIDTH), truncated to MEM_AW. Address bits below word granularity are ignored.
- **Memory issue**
  - In the grant cycle: mem_en_o = 1 only if in window.
  - mem_we_o, mem_be_o and mem_wdata_o carry the winner's fields.
  - When mem_en_o = 0, all mem_* outputs are 0.
- **Response register**
  - resp_valid, resp_port and resp_err are captured at the grant edge.
  - The next cycle drives rvalid_o[resp_port] = 1 and err_o[resp_port] = resp_err.
  - rdata_o = mem_rdata_i for in-window reads, and 0 for writes, errors or no response.
- **Writes** also produce an rvalid (Ibex protocol), with rdata_o = 0.
- **Out-of-window access**: granted, memory untouched, err_o = 1 next cycle.
- **Interface rules**
  - No back-pressure: one grant and one response per cycle, fully pipelined.
  - A grant in cycle N and the response from cycle N-1 coexist on different or same ports.
- **Reset**
  - Assertion mid-transaction clears resp_valid immediately (asynchronous). The pending response is dropped, not replayed.
  - The round-robin pointer returns to 0.

## Timing
- Reset values:
  - gnt_o = 0, rvalid_o = 0, err_o = 0, rdata_o = 0.
  - mem_en_o = 0, mem_we_o = 0, mem_be_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- gnt_o and the mem_* outputs are combinational from req_i/addr_i and the arbitration state (0 register stages).
- Response latency: exactly 1 cycle from the grant edge to rvalid_o, for every access.
- Throughput: 1 access per cycle across all ports.
- Round-robin fairness: a continuously requesting port waits at most NUM_PORTS-1 cycles.
- Masters must hold req_i and the request fields stable until granted. The arbiter never grants a port whose req_i is low.

## Test plan
- **Single read**: SRAM model preloaded with word 5 = 32'hDEAD_BEEF. Port 0 reads addr 32'h14.
  - Required: gnt_o = 2'b01 in the same cycle, mem_addr_o = 5, mem_en_o = 1.
  - Next cycle: rvalid_o = 2'b01, rdata_o = 32'hDEAD_BEEF, err_o = 0.
- **Write then read**: port 1 writes 32'h1234_5678 with be = 4'b0011 to addr 32'h8, then reads it back.
  - Required: write rvalid with rdata_o = 0.
  - Readback returns 32'hXXXX_5678, where the upper half is the old contents.
- **Round-robin contention**: both ports hold req_i for 6 cycles.
  - Required: grants alternate 01, 10, 01, 10, 01, 10.
  - Each rvalid follows its grant by exactly 1 cycle.
  - Repeat with ARB_MODE = 1: port 0 is granted all 6 cycles.
- **Out of window**: MEM_WORDS = 4096. Read addr 32'h0000_4000.
  - Required: grant, mem_en_o = 0.
  - Next cycle: rvalid_o and err_o set for that port, rdata_o = 0.
  - Addr 32'h3FFC is in window (no error).
- **Reset mid-operation**: assert rst low in the cycle after a grant, before the response edge completes.
  - Required: rvalid_o = 0 immediately and all outputs at reset values.
  - After release, the first contended grant goes to port 0.
- **Parametrised build**: NUM_PORTS = 4, DATA_WIDTH = 64, MEM_BASE = 32'h1000_0000. Ports 0–3 request simultaneously every cycle.
  - Required: grant order 0, 1, 2, 3, 0, …
  - 64-bit data round-trips, with mem_addr_o = (addr - 32'h1000_0000) >> 3.
